// File: rtl/frame_ctrl_pkg.sv
// frame_ctrl_pkg: shared constants and FSM state encoding for the frame controller.
//   ScreenWDefault / ScreenHDefault : default visible screen size in pixels
//   TickCyclesDefault               : clock cycles per frame (50 MHz / 60 Hz)
//   ColourW / CoordW                : pixel colour and coordinate widths
//   state_e                         : frame controller FSM states
package frame_ctrl_pkg;

   localparam int unsigned ScreenWDefault    = 160;
   localparam int unsigned ScreenHDefault    = 120;
   localparam int unsigned TickCyclesDefault = 833334;
   localparam int unsigned ColourW           = 3;
   localparam int unsigned CoordW            = 8;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StClear    = 3'd1,
      StDrawGo   = 3'd2,
      StDrawWait = 3'd3,
      StWaitTick = 3'd4
   } state_e;

endpackage

// File: rtl/frame_ctrl_tick.sv
// frame_tick_gen: free-running frame period counter.
//   clock      in  system clock
//   resetn     in  synchronous active-low reset (counter to 0)
//   frame_tick out one-cycle pulse while the counter sits at TICK_CYCLES-1
module frame_tick_gen #(
   parameter int unsigned TICK_CYCLES = 833334
) (
   input  logic clock,
   input  logic resetn,
   output logic frame_tick
);

   localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign frame_tick = (cnt_q == CntLast);

endmodule

// File: rtl/frame_ctrl.sv
// frame_ctrl: per-frame sequencer for a VGA pixel adapter. Each frame clears the screen
// to BG_COLOUR by raster scan, starts an external shape drawer, forwards its pixels, then
// waits for the next frame tick. Ticks that land while a frame is still busy are kept as
// a single pending start and flagged through the sticky overrun output.
//   clock, resetn          clock and synchronous active-low reset
//   enable                 run frames while high (a started frame always completes)
//   draw_done              drawer finished (single-cycle pulse)
//   draw_x/y/colour/plot   drawer pixel stream, forwarded while drawing
//   draw_go                start pulse to the drawer
//   out_x/y/colour, plot   pixel write port to the VGA adapter
//   frame_tick             one-cycle pulse every TICK_CYCLES cycles
//   overrun                sticky: a frame outlasted one tick period
module frame_ctrl
   import frame_ctrl_pkg::*;
#(
   parameter int unsigned        SCREEN_W    = ScreenWDefault,
   parameter int unsigned        SCREEN_H    = ScreenHDefault,
   parameter int unsigned        TICK_CYCLES = TickCyclesDefault,
   parameter logic [ColourW-1:0] BG_COLOUR   = 3'b000
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               enable,
   input  logic               draw_done,
   input  logic [CoordW-1:0]  draw_x,
   input  logic [CoordW-1:0]  draw_y,
   input  logic [ColourW-1:0] draw_colour,
   input  logic               draw_plot,
   output logic               draw_go,
   output logic [CoordW-1:0]  out_x,
   output logic [CoordW-1:0]  out_y,
   output logic [ColourW-1:0] out_colour,
   output logic               plot,
   output logic               frame_tick,
   output logic               overrun
);

   localparam logic [CoordW-1:0] XLast = CoordW'(SCREEN_W - 1);
   localparam logic [CoordW-1:0] YLast = CoordW'(SCREEN_H - 1);

   state_e             state_q, state_d;
   logic [CoordW-1:0]  x_q, x_d;
   logic [CoordW-1:0]  y_q, y_d;
   logic               pending_q, pending_d;
   logic               overrun_q, overrun_d;
   logic               in_frame;

   frame_tick_gen #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick (
      .clock      (clock),
      .resetn     (resetn),
      .frame_tick (frame_tick)
   );

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      in_frame  = (state_q == StClear) || (state_q == StDrawGo) || (state_q == StDrawWait);

      // A tick while the frame is still busy becomes one pending start.
      if (frame_tick && in_frame) begin
         pending_d = 1'b1;
         overrun_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StClear;
         end
         StClear: begin
            if (x_q == XLast) begin
               x_d = '0;
               if (y_q == YLast) begin
                  y_d     = '0;
                  state_d = StDrawGo;
               end else begin
                  y_d = y_q + 1'b1;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         StDrawGo: begin
            state_d = StDrawWait;
         end
         StDrawWait: begin
            if (draw_done) state_d = StWaitTick;
         end
         StWaitTick: begin
            // The pending start is used up on the first WAIT_TICK cycle.
            pending_d = 1'b0;
            if (!enable) begin
               state_d = StIdle;
            end else if (frame_tick || pending_q) begin
               state_d = StClear;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q   <= StIdle;
         x_q       <= '0;
         y_q       <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   // Outputs decode from registered state; only DRAW_WAIT passes the drawer straight through.
   always_comb begin
      draw_go    = 1'b0;
      plot       = 1'b0;
      out_x      = '0;
      out_y      = '0;
      out_colour = '0;
      case (state_q)
         StClear: begin
            plot       = 1'b1;
            out_x      = x_q;
            out_y      = y_q;
            out_colour = BG_COLOUR;
         end
         StDrawGo: begin
            draw_go = 1'b1;
         end
         StDrawWait: begin
            plot       = draw_plot;
            out_x      = draw_x;
            out_y      = draw_y;
            out_colour = draw_colour;
         end
         default: begin
         end
      endcase
   end

   assign overrun = overrun_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Bench for frame_ctrl with a 4x3 screen and a 40-cycle frame period.
module tb_frame_ctrl;

   localparam int W = 4;
   localparam int H = 3;
   localparam int T = 40;

   localparam int PIdle  = 0;
   localparam int PClear = 1;
   localparam int PGo    = 2;
   localparam int PWait  = 3;
   localparam int PTick  = 4;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       draw_done = 1'b0;
   logic [7:0] draw_x = 8'd0;
   logic [7:0] draw_y = 8'd0;
   logic [2:0] draw_colour = 3'd0;
   logic       draw_plot = 1'b0;
   logic       draw_go;
   logic [7:0] out_x;
   logic [7:0] out_y;
   logic [2:0] out_colour;
   logic       plot;
   logic       frame_tick;
   logic       overrun;

   always #5 clock = ~clock;

   frame_ctrl #(
      .SCREEN_W    (W),
      .SCREEN_H    (H),
      .TICK_CYCLES (T),
      .BG_COLOUR   (3'b000)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .enable      (enable),
      .draw_done   (draw_done),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .draw_colour (draw_colour),
      .draw_plot   (draw_plot),
      .draw_go     (draw_go),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_colour  (out_colour),
      .plot        (plot),
      .frame_tick  (frame_tick),
      .overrun     (overrun)
   );

   int total = 0;
   int bad = 0;

   // Behavioural model: frame phase, linear pixel index, cycles since reset.
   int m_phase = PIdle;
   int m_pix = 0;
   int m_cyc = 0;
   bit m_pend = 1'b0;
   bit m_ovr = 1'b0;
   bit m_known = 1'b0;

   function automatic bit m_tick();
      return (m_cyc % T) == (T - 1);
   endfunction

   function automatic logic [22:0] exp_vec();
      logic       go = 1'b0;
      logic       pl = 1'b0;
      logic [7:0] x = 8'd0;
      logic [7:0] y = 8'd0;
      logic [2:0] c = 3'd0;
      case (m_phase)
         PClear: begin
            pl = 1'b1;
            x  = 8'(m_pix % W);
            y  = 8'(m_pix / W);
            c  = 3'b000;
         end
         PGo: go = 1'b1;
         PWait: begin
            pl = draw_plot;
            x  = draw_x;
            y  = draw_y;
            c  = draw_colour;
         end
         default: ;
      endcase
      return {go, pl, x, y, c, m_tick(), m_ovr};
   endfunction

   always @(posedge clock) begin
      if (!resetn) begin
         m_known <= 1'b1;
         m_phase <= PIdle;
         m_pix   <= 0;
         m_cyc   <= 0;
         m_pend  <= 1'b0;
         m_ovr   <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_tick() && (m_phase == PClear || m_phase == PGo || m_phase == PWait)) begin
            m_pend <= 1'b1;
            m_ovr  <= 1'b1;
         end else if (m_phase == PTick) begin
            m_pend <= 1'b0;
         end
         case (m_phase)
            PIdle: if (enable) begin
               m_phase <= PClear;
               m_pix   <= 0;
            end
            PClear: begin
               if (m_pix == W * H - 1) m_phase <= PGo;
               else m_pix <= m_pix + 1;
            end
            PGo: m_phase <= PWait;
            PWait: if (draw_done) m_phase <= PTick;
            PTick: begin
               if (!enable) begin
                  m_phase <= PIdle;
               end else if (m_tick() || m_pend) begin
                  m_phase <= PClear;
                  m_pix   <= 0;
               end
            end
            default: m_phase <= PIdle;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (m_known) begin
         total++;
         if ({draw_go, plot, out_x, out_y, out_colour, frame_tick, overrun} != exp_vec()) begin
            bad++;
            $display("FAIL model_cmp t=%0t got go=%b plot=%b x=%0d y=%0d col=%0d tick=%b ovr=%b want %h",
                     $time, draw_go, plot, out_x, out_y, out_colour, frame_tick, overrun, exp_vec());
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   // Step until draw_go is seen (checked at +3 of each cycle); returns plot statistics.
   task automatic wait_go(output int npl, output int lx, output int ly, output int ncol,
                          output bit seen);
      npl = 0; lx = -1; ly = -1; ncol = 0; seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         nxt();
         #2;
         if (plot) begin
            npl++;
            lx = int'(out_x);
            ly = int'(out_y);
            if (out_colour != 3'b000) ncol++;
         end
         if (draw_go) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  npl, lx, ly, ncol, n, bp, bg;
      bit  seen;

      resetn = 1'b0;
      repeat (3) nxt();
      #2;
      chk("rst_plot", int'(plot), 0);
      chk("rst_draw_go", int'(draw_go), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_out_x", int'(out_x), 0);

      // Frame 1: full clear, then draw_go.
      resetn = 1'b1;
      enable = 1'b1;
      wait_go(npl, lx, ly, ncol, seen);
      chk("f1_go_seen", int'(seen), 1);
      chk("f1_clear_pixels", npl, 12);
      chk("f1_last_x", lx, 3);
      chk("f1_last_y", ly, 2);
      chk("f1_clear_colour", ncol, 0);

      // Passthrough in DRAW_WAIT.
      nxt();
      draw_x = 8'd2; draw_y = 8'd1; draw_colour = 3'b101; draw_plot = 1'b1;
      #2;
      chk("pass_x", int'(out_x), 2);
      chk("pass_y", int'(out_y), 1);
      chk("pass_colour", int'(out_colour), 5);
      chk("pass_plot", int'(plot), 1);

      // draw_done five cycles after draw_go.
      repeat (3) nxt();
      nxt();
      draw_done = 1'b1; draw_plot = 1'b0;
      nxt();
      draw_done = 1'b0;
      n = 0; bp = 0; seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #2;
         if (plot) bp++;
         if (frame_tick) begin
            seen = 1'b1;
            break;
         end
         nxt();
         n++;
      end
      chk("wt_tick_seen", int'(seen), 1);
      chk("wt_plot_while_waiting", bp, 0);
      chk("wt_cycles_to_tick", n, 20);
      chk("wt_no_overrun", int'(overrun), 0);
      nxt();
      #2;
      chk("f2_start_plot", int'(plot), 1);
      chk("f2_start_x", int'(out_x), 0);
      chk("f2_start_y", int'(out_y), 0);

      // Frame 2: drawer holds for 50 cycles, tick goes pending.
      wait_go(npl, lx, ly, ncol, seen);
      chk("f2_go_seen", int'(seen), 1);
      repeat (50) nxt();
      #2;
      chk("ovr_set", int'(overrun), 1);
      nxt();
      draw_done = 1'b1;
      nxt();
      draw_done = 0;
      #2;
      chk("ovr_waittick_plot", int'(plot), 0);
      nxt();
      #2;
      chk("ovr_restart_plot", int'(plot), 1);
      chk("ovr_restart_x", int'(out_x), 0);
      chk("ovr_restart_tick", int'(frame_tick), 0);

      // Frame 3: enable drops mid-clear; frame still completes, then IDLE.
      nxt();
      nxt();
      enable = 1'b0;
      wait_go(npl, lx, ly, ncol, seen);
      chk("f3_go_seen", int'(seen), 1);
      chk("f3_rest_of_clear", npl, 9);
      nxt();
      nxt();
      nxt();
      draw_done = 1'b1;
      nxt();
      draw_done = 1'b0;
      bp = 0; bg = 0;
      for (int i = 0; i < 20; i++) begin
         nxt();
         #2;
         if (plot) bp++;
         if (draw_go) bg++;
      end
      chk("idle_no_plot", bp, 0);
      chk("idle_no_go", bg, 0);

      // Reset at pixel 6 of a clear.
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         nxt();
         #2;
         if (plot && out_x == 8'd2 && out_y == 8'd1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("px6_seen", int'(seen), 1);
      chk("px6_overrun_before", int'(overrun), 1);
      resetn = 1'b0;
      enable = 1'b0;
      nxt();
      #2;
      chk("rst2_plot", int'(plot), 0);
      chk("rst2_overrun", int'(overrun), 0);
      chk("rst2_draw_go", int'(draw_go), 0);
      nxt();
      resetn = 1'b1;
      nxt();
      draw_done = 1'b1;
      nxt();
      draw_done = 1'b0;
      bp = 0; bg = 0;
      for (int i = 0; i < 10; i++) begin
         nxt();
         #2;
         if (plot) bp++;
         if (draw_go) bg++;
      end
      chk("rst2_late_done_plot", bp, 0);
      chk("rst2_late_done_go", bg, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
